// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN (round-robin tie break).
package wb_arbiter_pkg;

    localparam int WB_AW              = 32;
    localparam int WB_DW              = 32;
    localparam int WB_SW              = WB_DW / 8;
    localparam int WB_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } wb_arb_state_t;

    // One-hot grant vector seen by the outside world for a given state.
    function automatic logic [1:0] grant_of(wb_arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        if (s == GRANT0) g = 2'b01;
        if (s == GRANT1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Wishbone classic bus bundle. The master modport drives the request side,
// the slave modport drives the response side.
interface wb_bus_t;
    import wb_arbiter_pkg::*;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [WB_SW-1:0] sel;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat_w;
    logic [WB_DW-1:0] dat_r;
    logic             ack;
    logic             err;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_arbiter_watchdog.sv
// Stall watchdog: counts waiting strobe cycles of the granted master and
// flags expiry on the cycle the count would reach TIMEOUT_CYCLES.
module wb_watchdog
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rstn_i,
    input  logic enable,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Count waiting cycles; any ack/err/grant loss restarts the count.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (!enable || clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Expire combinationally so err/abort land on the Nth waiting cycle itself.
    assign expired = enable & tick & ~clear & (r_cnt == LIMIT);

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: m0 (instruction) and m1 (data) share s_bus.
// Grant is registered (one cycle from request to bus), held for the whole
// cyc window, handed over without an idle bubble, and aborted by a watchdog
// if the slave stalls. Optional macro WB_ARB_ROUND_ROBIN_EN: ties go to the
// master not granted most recently; otherwise m1 always wins a tie.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn_i,
    wb_bus_t.slave     m0_bus,
    wb_bus_t.slave     m1_bus,
    wb_bus_t.master    s_bus,
    output logic [1:0] grant_o,
    output logic       timeout_o
);

    wb_arb_state_t r_state;
    wb_arb_state_t w_state_nxt;

    // Per-master lockout after an abort, released once that master drops cyc.
    logic [1:0] r_blk;

    logic w_req0;
    logic w_req1;
    logic w_tie_m0;
    logic w_gnt_cyc;
    logic w_gnt_stb;
    logic w_drop;
    logic w_wd_en;
    logic w_wd_clr;
    logic w_wd_tick;
    logic w_expired;

    assign w_req0 = m0_bus.cyc & m0_bus.stb & ~r_blk[0];
    assign w_req1 = m1_bus.cyc & m1_bus.stb & ~r_blk[1];

`ifdef WB_ARB_ROUND_ROBIN_EN
    // Last-grant marker: 1 = m1 was granted most recently.
    logic r_last_m1;

    // Track who was granted last so a tie goes to the other master.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last_m1 <= 1'b1;
        end else if (w_state_nxt == GRANT0) begin
            r_last_m1 <= 1'b0;
        end else if (w_state_nxt == GRANT1) begin
            r_last_m1 <= 1'b1;
        end
    end

    assign w_tie_m0 = r_last_m1;
`else
    assign w_tie_m0 = 1'b0;
`endif

    // Qualifiers of whichever master currently owns the bus.
    assign w_gnt_cyc = (r_state == GRANT0) ? m0_bus.cyc :
                       (r_state == GRANT1) ? m1_bus.cyc : 1'b0;
    assign w_gnt_stb = (r_state == GRANT0) ? m0_bus.stb :
                       (r_state == GRANT1) ? m1_bus.stb : 1'b0;

    // Owner releasing the bus this cycle (grant is about to change).
    assign w_drop    = ((r_state == GRANT0) | (r_state == GRANT1)) & ~w_gnt_cyc;

    assign w_wd_en   = (r_state == GRANT0) | (r_state == GRANT1);
    assign w_wd_tick = w_gnt_cyc & w_gnt_stb & ~s_bus.ack;
    assign w_wd_clr  = s_bus.ack | s_bus.err | w_drop;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            wb_watchdog #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_wd (
                .clk     (clk),
                .rstn_i  (rstn_i),
                .enable  (w_wd_en),
                .clear   (w_wd_clr),
                .tick    (w_wd_tick),
                .expired (w_expired)
            );
        end else begin : g_no_wd
            assign w_expired = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort lockout: set on watchdog expiry, cleared once the master lets go.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_blk <= 2'b00;
        end else begin
            if ((r_state == GRANT0) && w_expired) r_blk[0] <= 1'b1;
            else if (!m0_bus.cyc)                 r_blk[0] <= 1'b0;
            if ((r_state == GRANT1) && w_expired) r_blk[1] <= 1'b1;
            else if (!m1_bus.cyc)                 r_blk[1] <= 1'b0;
        end
    end

    // Next-state: arbitrate from IDLE, hand over directly on cyc release.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) w_state_nxt = w_tie_m0 ? GRANT0 : GRANT1;
                else if (w_req0)      w_state_nxt = GRANT0;
                else if (w_req1)      w_state_nxt = GRANT1;
            end
            GRANT0: begin
                if (w_expired)        w_state_nxt = ABORT;
                else if (!m0_bus.cyc) w_state_nxt = w_req1 ? GRANT1 : IDLE;
            end
            GRANT1: begin
                if (w_expired)        w_state_nxt = ABORT;
                else if (!m1_bus.cyc) w_state_nxt = w_req0 ? GRANT0 : IDLE;
            end
            ABORT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bus steering: owner's request passes through, responses go only to it.
    always_comb begin
        s_bus.cyc    = 1'b0;
        s_bus.stb    = 1'b0;
        s_bus.we     = 1'b0;
        s_bus.sel    = '0;
        s_bus.adr    = '0;
        s_bus.dat_w  = '0;
        m0_bus.ack   = 1'b0;
        m0_bus.err   = 1'b0;
        m0_bus.dat_r = '0;
        m1_bus.ack   = 1'b0;
        m1_bus.err   = 1'b0;
        m1_bus.dat_r = '0;
        case (r_state)
            GRANT0: begin
                s_bus.cyc    = m0_bus.cyc & ~w_expired;
                s_bus.stb    = m0_bus.stb & ~w_expired;
                s_bus.we     = m0_bus.we;
                s_bus.sel    = m0_bus.sel;
                s_bus.adr    = m0_bus.adr;
                s_bus.dat_w  = m0_bus.dat_w;
                m0_bus.ack   = s_bus.ack;
                m0_bus.err   = s_bus.err | w_expired;
                m0_bus.dat_r = s_bus.dat_r;
            end
            GRANT1: begin
                s_bus.cyc    = m1_bus.cyc & ~w_expired;
                s_bus.stb    = m1_bus.stb & ~w_expired;
                s_bus.we     = m1_bus.we;
                s_bus.sel    = m1_bus.sel;
                s_bus.adr    = m1_bus.adr;
                s_bus.dat_w  = m1_bus.dat_w;
                m1_bus.ack   = s_bus.ack;
                m1_bus.err   = s_bus.err | w_expired;
                m1_bus.dat_r = s_bus.dat_r;
            end
            default: ;
        endcase
    end

    assign grant_o   = grant_of(r_state);
    assign timeout_o = w_expired;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, max cycles a granted strobe waits for ack; 0 disables the watchdog.
REQ-002 clk  input  1  core clock; all state updates on its rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 m0_bus  wb_bus_t.slave  interface  instruction port, driven by the instruction cache.
REQ-005 m1_bus  wb_bus_t.slave  interface  data port, driven by the load/store unit.
REQ-006 s_bus  wb_bus_t.master  interface  single shared memory port.
REQ-007 grant_o  output  2  one-hot current grant: bit0 = m0, bit1 = m1; 00 = none.
REQ-008 timeout_o  output  1  one-cycle pulse when the watchdog aborts a transfer.

Function
REQ-009 State machine states SHALL be IDLE, GRANT0, GRANT1 and ABORT.
REQ-010 A request is cyc=1 and stb=1 on a master port.
REQ-011 Request seen in IDLE at cycle N -> grant registered -> s_bus cyc/stb driven at N+1.
- Arbitration-to-bus latency: exactly 1 cycle.
REQ-012 While granted, the master's cyc, stb, we, sel, adr and write data SHALL pass combinationally to s_bus.
- s_bus ack, err and read data SHALL return only to the granted master.
REQ-013 Non-granted master SHALL see ack=0, err=0, read data=0; its request stays pending and is never dropped.
REQ-014 Grant SHALL be held while the granted master keeps cyc=1, including multi-beat bursts with stb gaps.
REQ-015 Granted master drops cyc: s_bus cyc SHALL fall the same cycle.
- Next state: other GRANTx if the other master is requesting; otherwise IDLE.
- No IDLE bubble on handover.
REQ-016 Simultaneous requests SHALL be resolved per REQ-024/REQ-025.
REQ-017 Watchdog counter SHALL increment each granted cycle with stb=1 and ack=0; it clears on ack, on err and on grant change.
REQ-018 Counter reaching TIMEOUT_CYCLES:
- assert err to the granted master for one cycle;
- pulse timeout_o;
- force s_bus cyc=0;
- enter ABORT.
REQ-019 ABORT SHALL last one cycle with no grant, then go to IDLE.
- The aborted master SHALL deassert cyc before it is re-granted.
REQ-020 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); with TIMEOUT_CYCLES=0 no counter is built and timeout_o=0.
REQ-021 A slave err SHALL be forwarded unchanged and SHALL NOT trigger ABORT.

Reset
REQ-022 Reset SHALL force the following:
- state IDLE, grant_o=00, timeout_o=0, counter 0;
- last-grant marker = m1 (so m0 wins the first tie);
- s_bus cyc/stb=0, both master ack/err=0.
REQ-023 Reset asserted mid-transfer SHALL drop s_bus cyc asynchronously; no pending request survives reset.

Configuration
REQ-024 Macro WB_ARB_ROUND_ROBIN_EN defined: a tie grants the master not granted most recently.
REQ-025 Macro undefined: fixed priority, m1 (data) always wins a tie; the last-grant marker is not built.

Structure
REQ-026 The shared package SHALL hold:
- the wb_arb_state_t enum (IDLE, GRANT0, GRANT1, ABORT);
- the default TIMEOUT_CYCLES constant.
REQ-027 Watchdog counter SHALL be sub-module wb_watchdog (inputs: enable, clear, tick; output: expired); all other logic lives in wb_arbiter.

Verification
REQ-028 Bench SHALL cover the scenarios below.
- m0 lone single read at adr 0x100, slave acks 2 cycles later:
  - grant_o=01 one cycle after request;
  - m0 receives the data word;
  - m1 sees ack=0;
  - grant_o=00 the cycle after m0 drops cyc.
- Both request in cycle 0 after reset, each does 1 beat:
  - with WB_ARB_ROUND_ROBIN_EN: grant sequence 01 then 10;
  - without it: 10 then 01;
  - handover with no IDLE cycle.
- m0 holds an 8-beat burst while m1 requests at beat 2:
  - m1 gets no ack until m0 drops cyc;
  - then grant_o=10 on the next cycle.
- TIMEOUT_CYCLES=4, slave never acks m1:
  - m1 err=1 and timeout_o=1 on the 4th waiting cycle;
  - one ABORT cycle with grant_o=00;
  - then m0's pending request is granted.
- rstn_i low during a granted m1 write:
  - s_bus cyc=0 immediately;
  - after release, grant_o=00 until a new request arrives.
